// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: upstream FIFO pop port plus downstream valid/ready stream.
// master = the reader, slave = the FIFO/sink side.
interface fifo_reader_if #(parameter int data_width = 32);
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [data_width-1:0] fifo_dout;
   logic                  m_valid;
   logic [data_width-1:0] m_data;
   logic                  m_ready;

   modport master (
      input  fifo_empty, fifo_dout, m_ready,
      output fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_dout, m_ready,
      input  fifo_rd_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_reader.sv
// Pops an upstream FIFO (1-cycle read latency) into a 3-entry skid buffer feeding a valid/ready stream.
// Optional delivered-word counter enabled by macro FIFO_READER_CNT_EN.
module fifo_reader #(
   parameter int data_width = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          flush,
   fifo_reader_if.master bus,
   output logic [15:0]   rd_count
);

   logic [1:0]                  occ;
   logic                        infl;
   logic [2:0][data_width-1:0]  mem;
   logic [2:0][data_width-1:0]  mem_nxt;
   logic                        push;
   logic                        pop;
   logic [1:0]                  wr_idx;

   // Issue a pop only if the buffer can absorb it together with any word already in flight.
   assign bus.fifo_rd_en = rst & cs & ~bus.fifo_empty & ~flush &
                           ((3'(occ) + 3'(infl)) < 3'd3);

   assign bus.m_valid = (occ != 2'd0);
   assign bus.m_data  = mem[0];

   assign pop    = bus.m_valid & bus.m_ready;
   assign push   = infl & ~flush;
   assign wr_idx = pop ? occ - 2'd1 : occ;

   // Head lives in mem[0]; a transfer shifts everything down one slot.
   always_comb begin
      mem_nxt = mem;
      if (pop)
         mem_nxt = {mem[2], mem[2:1]};
      if (push)
         mem_nxt[wr_idx] = bus.fifo_dout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ  <= '0;
         infl <= 1'b0;
         mem  <= '0;
      end else begin
         infl <= bus.fifo_rd_en;
         mem  <= mem_nxt;
         if (flush)
            occ <= '0;
         else
            occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef FIFO_READER_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rd_count <= '0;
      else if (pop)
         rd_count <= rd_count + 16'd1;
   end
`else
   assign rd_count = '0;
`endif

endmodule
